// File: rtl/shift_sequencer.sv
// Iterative SLL/SRL/SRA sequencer: STEP bit positions per clock, valid/ready on both sides.
module shift_sequencer #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned STEP = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [XLEN-1:0]          req_a,
    input  logic [$clog2(XLEN)-1:0]  req_shamt,
    input  logic [1:0]               req_type,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [XLEN-1:0]          rsp_r,
    output logic                     busy
);

    localparam int unsigned SHW = $clog2(XLEN);

    localparam logic [1:0] OP_SLL  = 2'b00;
    localparam logic [1:0] OP_SRL  = 2'b01;
    localparam logic [1:0] OP_SRA  = 2'b10;
    localparam logic [1:0] OP_PASS = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [SHW-1:0]    count_q, count_d;
    logic [1:0]        typ_q, typ_d;
    logic [SHW-1:0]    step_amt;
    logic [XLEN-1:0]   shifted;

    // Partial shift for this cycle: min(STEP, remaining) in the latched direction
    always_comb begin
        step_amt = (count_q < SHW'(STEP)) ? count_q : SHW'(STEP);
        shifted  = opnd_q;
        case (typ_q)
            OP_SLL:  shifted = opnd_q << step_amt;
            OP_SRL:  shifted = opnd_q >> step_amt;
            OP_SRA:  shifted = $unsigned($signed(opnd_q) >>> step_amt);
            default: shifted = opnd_q;
        endcase
    end

    // Next-state and working-register update; flush forces IDLE from any state
    always_comb begin
        state_d   = state_q;
        opnd_d    = opnd_q;
        count_d   = count_q;
        typ_d     = typ_q;
        req_ready = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = !flush;
                if (req_valid && !flush) begin
                    opnd_d  = req_a;
                    count_d = req_shamt;
                    typ_d   = req_type;
                    if ((req_shamt == '0) || (req_type == OP_PASS)) begin
                        state_d = DONE;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                opnd_d  = shifted;
                count_d = count_q - step_amt;
                if (count_q == step_amt) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d = IDLE;
        end
    end

    // State and working registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            opnd_q  <= '0;
            count_q <= '0;
            typ_q   <= '0;
        end else begin
            state_q <= state_d;
            opnd_q  <= opnd_d;
            count_q <= count_d;
            typ_q   <= typ_d;
        end
    end

    assign rsp_valid = (state_q == DONE);
    assign rsp_r     = opnd_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed and randomized checks of shift_sequencer for STEP=1 and STEP=4.
module tb_shift_sequencer;

    localparam int unsigned NRAND = 1000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        flush1, req_valid1, req_ready1, rsp_valid1, rsp_ready1, busy1;
    logic [31:0] req_a1, rsp_r1;
    logic [4:0]  req_shamt1;
    logic [1:0]  req_type1;
    logic        flush4, req_valid4, req_ready4, rsp_valid4, rsp_ready4, busy4;
    logic [31:0] req_a4, rsp_r4;
    logic [4:0]  req_shamt4;
    logic [1:0]  req_type4;

    shift_sequencer #(.XLEN(32), .STEP(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush1),
        .req_valid(req_valid1), .req_ready(req_ready1), .req_a(req_a1),
        .req_shamt(req_shamt1), .req_type(req_type1),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_r(rsp_r1), .busy(busy1)
    );

    shift_sequencer #(.XLEN(32), .STEP(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .flush(flush4),
        .req_valid(req_valid4), .req_ready(req_ready4), .req_a(req_a4),
        .req_shamt(req_shamt4), .req_type(req_type4),
        .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready4), .rsp_r(rsp_r4), .busy(busy4)
    );

    typedef struct {
        logic [31:0] a;
        logic [4:0]  sh;
        logic [1:0]  ty;
        logic [31:0] exp_r;
        int          exp_lat;
    } vec_t;

    vec_t vecs [12];
    int checks = 0;
    int errors = 0;
    logic [31:0] expq [$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_shift(input logic [31:0] a, input logic [4:0] sh,
                                              input logic [1:0] ty);
        case (ty)
            2'b00:   return a << sh;
            2'b01:   return a >> sh;
            2'b10:   return $unsigned($signed(a) >>> sh);
            default: return a;
        endcase
    endfunction

    // Wait on dut1 rsp_valid, counting cycles; caller is at a negedge that counts as cycle 1
    task automatic wait_valid1(input int maxc, output int n);
        n = 1;
        while (!rsp_valid1 && n < maxc) begin
            @(negedge clk);
            n++;
        end
        if (!rsp_valid1) n = 0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int   lat;
        logic busy_ok;
        @(negedge clk);
        req_a1 = v.a; req_shamt1 = v.sh; req_type1 = v.ty;
        req_valid1 = 1'b1; rsp_ready1 = 1'b1;
        #1 check($sformatf("v%0d_req_ready", idx), 32'(req_ready1), 32'd1);
        @(posedge clk);
        lat = 0;
        busy_ok = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) begin
                req_valid1 = 1'b0; req_a1 = ~v.a; req_shamt1 = 5'd31; req_type1 = 2'b00;
            end
            if (!busy1) busy_ok = 1'b0;
            if (rsp_valid1) begin
                lat = k;
                break;
            end
        end
        check($sformatf("v%0d_latency", idx), 32'(lat), 32'(v.exp_lat));
        check($sformatf("v%0d_rsp_r", idx), rsp_r1, v.exp_r);
        check($sformatf("v%0d_busy", idx), 32'(busy_ok), 32'd1);
        @(posedge clk);
        @(negedge clk);
        check($sformatf("v%0d_idle_after", idx), {30'd0, busy1, rsp_valid1}, 32'd0);
    endtask

    task automatic run4(input logic [31:0] a, input logic [4:0] sh, input logic [1:0] ty,
                        input logic [31:0] exp_r, input int exp_lat, input string name);
        int lat;
        @(negedge clk);
        req_a4 = a; req_shamt4 = sh; req_type4 = ty; req_valid4 = 1'b1; rsp_ready4 = 1'b1;
        @(posedge clk);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            req_valid4 = 1'b0;
            if (rsp_valid4) begin
                lat = k;
                break;
            end
        end
        check({name, "_latency"}, 32'(lat), 32'(exp_lat));
        check({name, "_rsp_r"}, rsp_r4, exp_r);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int   n;
        int   sent, recv, cyc;
        bit   acc;
        logic quiet;

        rst_n = 1'b0;
        flush1 = 1'b0; req_valid1 = 1'b0; rsp_ready1 = 1'b0;
        req_a1 = '0; req_shamt1 = '0; req_type1 = '0;
        flush4 = 1'b0; req_valid4 = 1'b0; rsp_ready4 = 1'b0;
        req_a4 = '0; req_shamt4 = '0; req_type4 = '0;

        vecs[0]  = '{32'h0000_0001, 5'd31, 2'b00, 32'h8000_0000, 32};
        vecs[1]  = '{32'h8000_0000, 5'd4,  2'b10, 32'hF800_0000, 5};
        vecs[2]  = '{32'h8000_0000, 5'd4,  2'b01, 32'h0800_0000, 5};
        vecs[3]  = '{32'hDEAD_BEEF, 5'd0,  2'b00, 32'hDEAD_BEEF, 1};
        vecs[4]  = '{32'hDEAD_BEEF, 5'd7,  2'b11, 32'hDEAD_BEEF, 1};
        vecs[5]  = '{32'h8000_0001, 5'd31, 2'b10, 32'hFFFF_FFFF, 32};
        vecs[6]  = '{32'hFFFF_FFFF, 5'd31, 2'b01, 32'h0000_0001, 32};
        vecs[7]  = '{32'hFFFF_FFFF, 5'd31, 2'b00, 32'h8000_0000, 32};
        vecs[8]  = '{32'h1234_5678, 5'd8,  2'b00, 32'h3456_7800, 9};
        vecs[9]  = '{32'h1234_5678, 5'd8,  2'b10, 32'h0012_3456, 9};
        vecs[10] = '{32'h7FFF_FFFF, 5'd31, 2'b10, 32'h0000_0000, 32};
        vecs[11] = '{32'hF000_0000, 5'd3,  2'b10, 32'hFE00_0000, 4};

        // reset state
        repeat (3) @(negedge clk);
        check("reset_rsp_valid", 32'(rsp_valid1), 32'd0);
        check("reset_rsp_r", rsp_r1, 32'd0);
        check("reset_busy", 32'(busy1), 32'd0);
        check("reset4", {rsp_r4[29:0], busy4, rsp_valid4}, 32'd0);
        rst_n = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i], i);

        // backpressure in DONE with the next request already waiting
        @(negedge clk);
        req_a1 = 32'h0000_00F0; req_shamt1 = 5'd2; req_type1 = 2'b00;
        req_valid1 = 1'b1; rsp_ready1 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_a1 = 32'hA5A5_0001; req_shamt1 = 5'd1; req_type1 = 2'b01;
        wait_valid1(10, n);
        check("bp_latency", 32'(n), 32'd3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("bp_hold%0d", i), {29'd0, rsp_valid1, req_ready1, busy1}, 32'b101);
            check($sformatf("bp_r%0d", i), rsp_r1, 32'h0000_03C0);
            @(negedge clk);
        end
        rsp_ready1 = 1'b1;
        #1 check("bp_handshake_req_ready", 32'(req_ready1), 32'd0);
        @(negedge clk);
        check("bp_idle", {30'd0, busy1, req_ready1}, 32'b01);
        @(posedge clk);
        @(negedge clk);
        check("bp_second_accept", 32'(busy1), 32'd1);
        req_valid1 = 1'b0;
        wait_valid1(10, n);
        check("bp_second_latency", 32'(n), 32'd2);
        check("bp_second_r", rsp_r1, 32'h52D2_8000);
        @(posedge clk);
        @(negedge clk);

        // flush in 3rd SHIFT cycle, then flush beats a request in IDLE
        req_a1 = 32'h1; req_shamt1 = 5'd20; req_type1 = 2'b00; req_valid1 = 1'b1; rsp_ready1 = 1'b1;
        @(posedge clk);
        @(negedge clk); req_valid1 = 1'b0;
        @(negedge clk);
        @(negedge clk); flush1 = 1'b1;
        @(negedge clk);
        check("flush_idle", {30'd0, busy1, rsp_valid1}, 32'd0);
        req_valid1 = 1'b1;
        #1 check("flush_blocks_req", 32'(req_ready1), 32'd0);
        @(negedge clk);
        flush1 = 1'b0; req_valid1 = 1'b0;
        check("flush_no_accept", 32'(busy1), 32'd0);
        quiet = 1'b1;
        repeat (25) begin
            @(negedge clk);
            if (rsp_valid1 || busy1) quiet = 1'b0;
        end
        check("flush_no_rsp", 32'(quiet), 32'd1);

        // reset in 3rd SHIFT cycle
        req_a1 = 32'h1; req_shamt1 = 5'd20; req_type1 = 2'b00; req_valid1 = 1'b1;
        @(posedge clk);
        @(negedge clk); req_valid1 = 1'b0;
        @(negedge clk);
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk);
        check("rst_mid_state", {30'd0, busy1, rsp_valid1}, 32'd0);
        check("rst_mid_r", rsp_r1, 32'd0);
        rst_n = 1'b1;
        quiet = 1'b1;
        repeat (25) begin
            @(negedge clk);
            if (rsp_valid1 || busy1) quiet = 1'b0;
        end
        check("rst_no_rsp", 32'(quiet), 32'd1);

        // flush beats rsp_ready in DONE
        req_a1 = 32'h3; req_shamt1 = 5'd1; req_type1 = 2'b00; req_valid1 = 1'b1; rsp_ready1 = 1'b0;
        @(posedge clk);
        @(negedge clk); req_valid1 = 1'b0;
        wait_valid1(5, n);
        check("flush_done_r", rsp_r1, 32'h6);
        flush1 = 1'b1; rsp_ready1 = 1'b1;
        @(negedge clk);
        flush1 = 1'b0;
        check("flush_done_drop", {30'd0, busy1, rsp_valid1}, 32'd0);

        // STEP=4 latency
        run4(32'hFFFF_0000, 5'd9, 2'b01, 32'h007F_FF80, 4, "s4_srl9");
        run4(32'h0000_0001, 5'd3, 2'b00, 32'h0000_0008, 2, "s4_sll3");

        // STEP=4 random stream with consumer stalls
        sent = 0; recv = 0; cyc = 0; acc = 1'b0;
        req_valid4 = 1'b0;
        while (recv < NRAND && cyc < 30000) begin
            @(negedge clk);
            cyc++;
            if (acc) begin
                req_valid4 = 1'b0;
                req_a4 = $urandom;
                req_shamt4 = 5'($urandom_range(0, 31));
                req_type4 = 2'($urandom_range(0, 3));
                acc = 1'b0;
            end
            if (!req_valid4 && sent < NRAND && $urandom_range(0, 3) != 0) begin
                req_a4 = $urandom;
                req_shamt4 = 5'($urandom_range(0, 31));
                req_type4 = 2'($urandom_range(0, 3));
                req_valid4 = 1'b1;
            end
            rsp_ready4 = ($urandom_range(0, 2) != 0);
            #1;
            if (rsp_valid4 && rsp_ready4) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rand_unexpected got %h expected none", rsp_r4);
                end else begin
                    check($sformatf("rand%0d", recv), rsp_r4, expq.pop_front());
                end
                recv++;
            end
            if (req_valid4 && req_ready4) begin
                expq.push_back(ref_shift(req_a4, req_shamt4, req_type4));
                sent++;
                acc = 1'b1;
            end
        end
        check("rand_count", 32'(recv), 32'(NRAND));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
